// File: rtl/arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arbiter_pkg
//   Shared types and default sizes for the bank-group round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE = nobody owns the path,
//                 GRANT = one group owns the command/data path).
//   DEF_NUM_GROUPS / DEF_MAX_BURST : default parameter values for the top.
// ---------------------------------------------------------------------------
package arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_GROUPS = 4;
  localparam int DEF_MAX_BURST  = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
//   Purely combinational round-robin selector. The search starts at the
//   group after 'last' and wraps modulo N, so 'last' itself has the lowest
//   priority.
//   Ports:
//     req  [N-1:0] in   request vector
//     last [W-1:0] in   most recently served group (lowest priority)
//     pick [W-1:0] out  winning group index (valid when any=1)
//     any          out  at least one request present
// ---------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] pick,
  output logic         any
);

  logic [W-1:0] base;
  logic [N-1:0] rot;
  logic [W-1:0] idx;

  // (a + b) mod N for operands already below N; N need not be a power of two.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (W+1)'(N)) s = s - (W+1)'(N);
    return s[W-1:0];
  endfunction

  // Rotation origin: the group right after 'last'.
  assign base = (last >= W'(N - 1)) ? '0 : last + W'(1);

  // Rotate so that rot[0] is the highest-priority candidate.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[wrap_add(base, W'(i))];
    end
  end

  // Fixed-priority encode: lowest set bit of the rotated vector.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) idx = W'(i);
    end
  end

  // Un-rotate back to an absolute group index.
  assign pick = wrap_add(base, idx);
  assign any  = |req;

endmodule

// File: rtl/bank_group_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bank_group_rr_arbiter
//   Grants the shared command/data path to one of NUM_GROUPS bank-group
//   schedulers at a time, with rotating priority and a programmable burst
//   limit that forces a hand-over.
//
//   Interface semantics: req and done are level signals sampled every cycle.
//   start[g] high means group g issues exactly one burst in that cycle; there
//   is no back-pressure. A grant from IDLE is combinational (start in the
//   same cycle req is seen); every release costs exactly one cycle with
//   start=0, during which the next owner is chosen.
//
//   Ports:
//     clk            in   clock
//     rst_n          in   synchronous active-low reset; also forces outputs low
//     req   [N-1:0]  in   group g has bursts pending
//     done  [N-1:0]  in   owner finished its sequence, release the grant
//     cfg_max_burst  in   bursts per grant before forced hand-over, 0=unlimited
//     start [N-1:0]  out  one-hot (or zero) burst strobe
//     sel   [SEL_W]  out  owning group index for the command mux
//     busy           out  FSM is in GRANT (doubles as state debug view)
// ---------------------------------------------------------------------------
module bank_group_rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_GROUPS = DEF_NUM_GROUPS,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int SEL_W      = $clog2(NUM_GROUPS),
  parameter int CNT_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_GROUPS-1:0] req,
  input  logic [NUM_GROUPS-1:0] done,
  input  logic [CNT_W-1:0]      cfg_max_burst,
  output logic [NUM_GROUPS-1:0] start,
  output logic [SEL_W-1:0]      sel,
  output logic                  busy
);

  arb_state_e            state_q, state_d;
  logic [SEL_W-1:0]      owner_q, owner_d;
  logic [SEL_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [SEL_W-1:0]      pick_base;
  logic [SEL_W-1:0]      pick;
  logic                  any_req;
  logic                  limit_hit;
  logic                  keep;
  logic [NUM_GROUPS-1:0] start_c;
  logic [SEL_W-1:0]      sel_c;

  // In GRANT the current owner is the rotation origin, so a release hands
  // over to the next requester and only falls back to the owner if it is
  // the sole one left.
  assign pick_base = (state_q == ARB_GRANT) ? owner_q : last_q;

  rr_priority_picker #(
    .N (NUM_GROUPS),
    .W (SEL_W)
  ) u_picker (
    .req  (req),
    .last (pick_base),
    .pick (pick),
    .any  (any_req)
  );

  // Limit is compared live so reprogramming mid-grant acts immediately.
  assign limit_hit = (cfg_max_burst != '0) && (cnt_q >= cfg_max_burst);
  assign keep      = req[owner_q] & ~done[owner_q] & ~limit_hit;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    start_c = '0;
    sel_c   = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          start_c[pick] = 1'b1;
          sel_c         = pick;
          state_d       = ARB_GRANT;
          owner_d       = pick;
          // The IDLE cycle already issued one burst.
          cnt_d         = CNT_W'(1);
        end
      end
      ARB_GRANT: begin
        if (keep) begin
          start_c[owner_q] = 1'b1;
          if (cnt_q < CNT_W'(MAX_BURST)) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // Release cycle: no burst, choose the successor.
          last_d = owner_q;
          cnt_d  = '0;
          if (any_req) begin
            owner_d = pick;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= SEL_W'(NUM_GROUPS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by reset so a grant drops in the same cycle rst_n falls.
  assign start = rst_n ? start_c : '0;
  assign sel   = rst_n ? sel_c : '0;
  assign busy  = rst_n && (state_q == ARB_GRANT);

endmodule

// File: tb/tb_bank_group_rr_arbiter.sv
module tb_bank_group_rr_arbiter;

  localparam int MAXB = 16;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4_n = 1'b0;
  logic [3:0] req4 = '0, done4 = '0, start4;
  logic [4:0] cfg4 = '0;
  logic [1:0] sel4;
  logic       busy4;

  logic       rst6_n = 1'b0;
  logic [5:0] req6 = '0, done6 = '0, start6;
  logic [4:0] cfg6 = '0;
  logic [2:0] sel6;
  logic       busy6;

  bank_group_rr_arbiter #(.NUM_GROUPS(4), .MAX_BURST(MAXB)) dut4 (
    .clk(clk), .rst_n(rst4_n), .req(req4), .done(done4), .cfg_max_burst(cfg4),
    .start(start4), .sel(sel4), .busy(busy4));

  bank_group_rr_arbiter #(.NUM_GROUPS(6), .MAX_BURST(MAXB)) dut6 (
    .clk(clk), .rst_n(rst6_n), .req(req6), .done(done6), .cfg_max_burst(cfg6),
    .start(start6), .sel(sel6), .busy(busy6));

  // ---------------- bookkeeping ----------------
  int compared = 0;
  int mismatched = 0;
  int inst = 0;
  int n = 4;
  int cyc = 0;

  // ---------------- reference model ----------------
  bit         m_busy;
  int         m_owner, m_last, m_used;
  logic [7:0] cur_req, cur_done;
  int         cur_cfg;
  bit         cur_rst_n;
  logic [7:0] exp_start, obs_start;
  int         exp_sel, obs_sel;
  bit         exp_busy, obs_busy;

  function automatic int rr_pick(input logic [7:0] r, input int from, input int nn);
    for (int d = 1; d <= nn; d++) begin
      if (r[3'((from + d) % nn)]) return (from + d) % nn;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[3'(i)]) return i;
    end
    return -1;
  endfunction

  // Predicts this cycle's outputs from the arbitration rules, then advances.
  task automatic model_cycle();
    int  p;
    bit  cont;
    exp_start = 8'h00;
    exp_sel   = 0;
    exp_busy  = 1'b0;
    if (!cur_rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_last = n - 1; m_used = 0;
      return;
    end
    exp_busy = m_busy;
    if (!m_busy) begin
      p = rr_pick(cur_req, m_last, n);
      exp_sel = m_owner;
      if (p >= 0) begin
        exp_start[3'(p)] = 1'b1;
        exp_sel = p;
        m_busy = 1'b1; m_owner = p; m_used = 1;
      end
    end else begin
      exp_sel = m_owner;
      cont = cur_req[3'(m_owner)] && !cur_done[3'(m_owner)] &&
             !(cur_cfg != 0 && m_used >= cur_cfg);
      if (cont) begin
        exp_start[3'(m_owner)] = 1'b1;
        if (m_used < MAXB) m_used++;
      end else begin
        m_last = m_owner;
        m_used = 0;
        p = rr_pick(cur_req, m_owner, n);
        if (p >= 0) m_owner = p;
        else m_busy = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [7:0] r, input logic [7:0] d, input int cfg, input bit rn);
    logic [7:0] mask;
    mask = (8'd1 << n) - 8'd1;
    @(negedge clk);
    cur_req = r & mask; cur_done = d & mask; cur_cfg = cfg; cur_rst_n = rn;
    if (inst == 0) begin
      req4 = cur_req[3:0]; done4 = cur_done[3:0]; cfg4 = 5'(cfg); rst4_n = rn;
    end else begin
      req6 = cur_req[5:0]; done6 = cur_done[5:0]; cfg6 = 5'(cfg); rst6_n = rn;
    end
    #1;
    model_cycle();
    if (inst == 0) begin
      obs_start = {4'b0, start4}; obs_sel = int'(sel4); obs_busy = busy4;
    end else begin
      obs_start = {2'b0, start6}; obs_sel = int'(sel6); obs_busy = busy6;
    end
    cyc++;
  endtask

  task automatic do_reset();
    drive(8'h00, 8'h00, 0, 1'b0);
    drive(8'h00, 8'h00, 0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    inst = 0; n = 4;
    for (int i = 0; i < 3; i++) begin
      drive(8'h0F, 8'h00, 0, 1'b0);
      compared++;
      if (obs_start !== 8'h00 || obs_busy !== 1'b0 || obs_sel !== 0) begin
        mismatched++;
        $display("FAIL reset_hold cyc %0d: got start=%b sel=%0d busy=%0b, want start=0 sel=0 busy=0",
                 cyc, obs_start, obs_sel, obs_busy);
      end
    end
    drive(8'h0F, 8'h00, 0, 1'b1);
    compared++;
    if (obs_start !== 8'h01 || obs_busy !== 1'b0 || obs_sel !== 0) begin
      mismatched++;
      $display("FAIL reset_first_grant cyc %0d: got start=%b sel=%0d busy=%0b, want start=00000001 sel=0 busy=0",
               cyc, obs_start, obs_sel, obs_busy);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int want[5] = '{0, 1, 2, 3, 0};
    int prev, g;
    logic [7:0] dv;
    inst = 0; n = 4;
    do_reset();
    prev = -1;
    for (int i = 0; i < 15; i++) begin
      dv = (m_busy && m_used == 2) ? (8'd1 << m_owner) : 8'h00;
      drive(8'h0F, dv, 0, 1'b1);
      compared++;
      if (obs_start !== exp_start || obs_sel !== exp_sel || obs_busy !== exp_busy) begin
        mismatched++;
        $display("FAIL round_robin cyc %0d: got start=%b sel=%0d busy=%0b, want start=%b sel=%0d busy=%0b",
                 cyc, obs_start, obs_sel, obs_busy, exp_start, exp_sel, exp_busy);
      end
      if (obs_start != 8'h00) begin
        g = onehot_idx(obs_start);
        if (g != prev) order.push_back(g);
        prev = g;
      end
    end
    for (int k = 0; k < 5; k++) begin
      compared++;
      if (k >= order.size() || order[k] != want[k]) begin
        mismatched++;
        $display("FAIL rr_order[%0d]: got %0d, want %0d", k, (k < order.size()) ? order[k] : -1, want[k]);
      end
    end
  endtask

  task automatic test_burst_limit();
    logic [7:0] pat[12] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h04,
                            8'h04, 8'h04, 8'h04, 8'h00, 8'h01, 8'h01};
    inst = 0; n = 4;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(8'h05, 8'h00, 4, 1'b1);
      compared++;
      if (obs_start !== pat[i]) begin
        mismatched++;
        $display("FAIL burst_limit_pattern step %0d: got start=%b, want %b", i, obs_start, pat[i]);
      end
      compared++;
      if (obs_start !== exp_start || obs_sel !== exp_sel || obs_busy !== exp_busy) begin
        mismatched++;
        $display("FAIL burst_limit cyc %0d: got start=%b sel=%0d busy=%0b, want start=%b sel=%0d busy=%0b",
                 cyc, obs_start, obs_sel, obs_busy, exp_start, exp_sel, exp_busy);
      end
    end
  endtask

  task automatic test_sole_limit();
    logic [7:0] pat[6] = '{8'h08, 8'h08, 8'h00, 8'h08, 8'h08, 8'h00};
    inst = 0; n = 4;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(8'h08, 8'h00, 2, 1'b1);
      compared++;
      if (obs_start !== pat[i] || obs_sel !== 3) begin
        mismatched++;
        $display("FAIL sole_limit step %0d: got start=%b sel=%0d, want start=%b sel=3",
                 i, obs_start, obs_sel, pat[i]);
      end
    end
  endtask

  task automatic test_unlimited_drop();
    int hi;
    inst = 0; n = 4;
    // Variant A: req[1] alone for 20 cycles, then nothing.
    do_reset();
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      drive(8'h02, 8'h00, 0, 1'b1);
      if (obs_start === 8'h02) hi++;
      compared++;
      if (obs_start !== exp_start || obs_sel !== exp_sel || obs_busy !== exp_busy) begin
        mismatched++;
        $display("FAIL unlimited cyc %0d: got start=%b sel=%0d busy=%0b, want start=%b sel=%0d busy=%0b",
                 cyc, obs_start, obs_sel, obs_busy, exp_start, exp_sel, exp_busy);
      end
    end
    compared++;
    if (hi != 20) begin
      mismatched++;
      $display("FAIL unlimited_count: got %0d cycles, want 20", hi);
    end
    drive(8'h00, 8'h00, 0, 1'b1);
    compared++;
    if (obs_start !== 8'h00 || obs_busy !== 1'b1 || obs_sel !== 1) begin
      mismatched++;
      $display("FAIL drop_release: got start=%b sel=%0d busy=%0b, want start=0 sel=1 busy=1",
               obs_start, obs_sel, obs_busy);
    end
    drive(8'h00, 8'h00, 0, 1'b1);
    compared++;
    if (obs_start !== 8'h00 || obs_busy !== 1'b0 || obs_sel !== 1) begin
      mismatched++;
      $display("FAIL drop_idle: got start=%b sel=%0d busy=%0b, want start=0 sel=1 busy=0",
               obs_start, obs_sel, obs_busy);
    end
    // Variant B: req[1] for 20 cycles, then req[2] takes over after one gap.
    do_reset();
    for (int i = 0; i < 20; i++) drive(8'h02, 8'h00, 0, 1'b1);
    drive(8'h04, 8'h00, 0, 1'b1);
    compared++;
    if (obs_start !== 8'h00 || obs_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL handover_gap: got start=%b busy=%0b, want start=0 busy=1", obs_start, obs_busy);
    end
    drive(8'h04, 8'h00, 0, 1'b1);
    compared++;
    if (obs_start !== 8'h04 || obs_sel !== 2 || obs_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL handover_grant: got start=%b sel=%0d busy=%0b, want start=00000100 sel=2 busy=1",
               obs_start, obs_sel, obs_busy);
    end
  endtask

  task automatic test_reset_mid_grant();
    inst = 0; n = 4;
    do_reset();
    for (int i = 0; i < 3; i++) drive(8'h01, 8'h00, 0, 1'b1);
    compared++;
    if (obs_start !== 8'h01 || obs_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_reset_grant: got start=%b busy=%0b, want start=00000001 busy=1", obs_start, obs_busy);
    end
    drive(8'h01, 8'h00, 0, 1'b0);
    compared++;
    if (obs_start !== 8'h00 || obs_busy !== 1'b0 || obs_sel !== 0) begin
      mismatched++;
      $display("FAIL reset_mid_grant: got start=%b sel=%0d busy=%0b, want start=0 sel=0 busy=0",
               obs_start, obs_sel, obs_busy);
    end
    drive(8'h01, 8'h00, 0, 1'b1);
    compared++;
    if (obs_start !== 8'h01 || obs_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset_regrant: got start=%b busy=%0b, want start=00000001 busy=0", obs_start, obs_busy);
    end
  endtask

  task automatic test_random_n6();
    int         wait_cnt[6];
    int         worst, cfg;
    logic [7:0] r, d;
    localparam int BOUND = 6 * (MAXB + 1);
    inst = 1; n = 6;
    do_reset();
    foreach (wait_cnt[g]) wait_cnt[g] = 0;
    cfg = int'($urandom_range(1, MAXB));
    r = 8'h00;
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) cfg = int'($urandom_range(1, MAXB));
      if (i % 4 == 0) r = 8'($urandom) | 8'($urandom);
      d = 8'($urandom) & 8'($urandom) & 8'($urandom);
      drive(r, d, cfg, 1'b1);
      compared++;
      if (obs_start !== exp_start || obs_sel !== exp_sel || obs_busy !== exp_busy) begin
        mismatched++;
        $display("FAIL random_n6 cyc %0d: got start=%b sel=%0d busy=%0b, want start=%b sel=%0d busy=%0b",
                 cyc, obs_start, obs_sel, obs_busy, exp_start, exp_sel, exp_busy);
      end
      compared++;
      if ($countones(obs_start) > 1) begin
        mismatched++;
        $display("FAIL onehot cyc %0d: got start=%b, want at most one bit", cyc, obs_start);
      end
      if (obs_start != 8'h00) begin
        compared++;
        if (obs_sel !== onehot_idx(obs_start)) begin
          mismatched++;
          $display("FAIL sel_matches_start cyc %0d: got sel=%0d, want %0d", cyc, obs_sel, onehot_idx(obs_start));
        end
      end
      worst = 0;
      for (int g = 0; g < 6; g++) begin
        if (cur_req[3'(g)] && !obs_start[3'(g)]) wait_cnt[g]++;
        else wait_cnt[g] = 0;
        if (wait_cnt[g] > worst) worst = wait_cnt[g];
      end
      compared++;
      if (worst > BOUND) begin
        mismatched++;
        $display("FAIL starvation cyc %0d: got wait %0d cycles, want <= %0d", cyc, worst, BOUND);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_burst_limit();
    test_sole_limit();
    test_unlimited_drop();
    test_reset_mid_grant();
    test_random_n6();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
